// File: rtl/pwm_decoder.sv
// Three-channel PWM decoder: measures high time and period per channel.
// Each channel flags itself stuck after 2*PWM_INTERVAL cycles without a rising edge.
module pwm_decoder #(
    parameter int PWM_INTERVAL = 1200,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RGB_R,
    input  logic             RGB_G,
    input  logic             RGB_B,
    output logic [CNT_W-1:0] duty_r,
    output logic [CNT_W-1:0] duty_g,
    output logic [CNT_W-1:0] duty_b,
    output logic [CNT_W-1:0] period_r,
    output logic [CNT_W-1:0] period_g,
    output logic [CNT_W-1:0] period_b,
    output logic [2:0]       valid,
    output logic [2:0]       stuck
);

    localparam int LIMIT = 2 * PWM_INTERVAL;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] PI_C    = CNT_W'(PWM_INTERVAL);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    if (CNT_W < $clog2(LIMIT + 1)) begin : g_width_chk
        $error("pwm_decoder: CNT_W too narrow for 2*PWM_INTERVAL");
    end

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STUCK
    } state_t;

    logic [2:0] pwm_in;
    assign pwm_in = {RGB_B, RGB_G, RGB_R};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             s2_d;
        logic             rise;
        state_t           state;
        logic [CNT_W-1:0] period_cnt;
        logic [CNT_W-1:0] high_cnt;
        logic [CNT_W-1:0] duty_q;
        logic [CNT_W-1:0] period_q;
        logic             valid_q;
        logic             stuck_q;

        assign rise = s2 & ~s2_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1         <= 1'b0;
                s2         <= 1'b0;
                s2_d       <= 1'b0;
                state      <= IDLE;
                period_cnt <= '0;
                high_cnt   <= '0;
                duty_q     <= '0;
                period_q   <= '0;
                valid_q    <= 1'b0;
                stuck_q    <= 1'b0;
            end else begin
                s1      <= pwm_in[i];
                s2      <= s1;
                s2_d    <= s2;
                valid_q <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state      <= MEASURE;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                        end
                    end
                    MEASURE: begin
                        // an edge wins over a simultaneous timeout
                        if (rise) begin
                            period_q   <= period_cnt;
                            duty_q     <= high_cnt;
                            valid_q    <= 1'b1;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                        end else if (period_cnt >= LIMIT_C) begin
                            state    <= STUCK;
                            stuck_q  <= 1'b1;
                            valid_q  <= 1'b1;
                            period_q <= PI_C;
                            duty_q   <= s2 ? PI_C : '0;
                        end else begin
                            period_cnt <= period_cnt + ONE;
                            if (s2) high_cnt <= high_cnt + ONE;
                        end
                    end
                    STUCK: begin
                        if (rise) begin
                            state      <= MEASURE;
                            stuck_q    <= 1'b0;
                            period_cnt <= ONE;
                            high_cnt   <= ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign duty_r   = g_ch[0].duty_q;
    assign duty_g   = g_ch[1].duty_q;
    assign duty_b   = g_ch[2].duty_q;
    assign period_r = g_ch[0].period_q;
    assign period_g = g_ch[1].period_q;
    assign period_b = g_ch[2].period_q;
    assign valid    = {g_ch[2].valid_q, g_ch[1].valid_q, g_ch[0].valid_q};
    assign stuck    = {g_ch[2].stuck_q, g_ch[1].stuck_q, g_ch[0].stuck_q};

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: directed waveforms push expected
// measurements; a negedge monitor pops and compares on every valid bit.
module tb_pwm_decoder;

    localparam int PI = 1200;
    localparam int W  = 16;

    logic         clk;
    logic         rst;
    logic         RGB_R, RGB_G, RGB_B;
    logic [W-1:0] duty_r, duty_g, duty_b;
    logic [W-1:0] period_r, period_g, period_b;
    logic [2:0]   valid, stuck;

    pwm_decoder #(.PWM_INTERVAL(PI), .CNT_W(W)) dut (
        .clk(clk), .rst(rst),
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .period_r(period_r), .period_g(period_g), .period_b(period_b),
        .valid(valid), .stuck(stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int period;
        int stk;
    } exp_t;

    exp_t q_r[$];
    exp_t q_g[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic all3     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input int ch, input int d, input int p, input int s);
        exp_t e;
        e.duty   = d;
        e.period = p;
        e.stk    = s;
        case (ch)
            0: q_r.push_back(e);
            1: q_g.push_back(e);
            default: q_b.push_back(e);
        endcase
    endtask

    task automatic check_ch(input int ch, input int d, input int p, input int s);
        exp_t e;
        int   n;
        case (ch)
            0: n = q_r.size();
            1: n = q_g.size();
            default: n = q_b.size();
        endcase
        chk($sformatf("valid_expected_ch%0d", ch), int'(n > 0), 1);
        if (n == 0) return;
        case (ch)
            0: e = q_r.pop_front();
            1: e = q_g.pop_front();
            default: e = q_b.pop_front();
        endcase
        chk($sformatf("duty_ch%0d", ch), d, e.duty);
        chk($sformatf("period_ch%0d", ch), p, e.period);
        chk($sformatf("stuck_ch%0d", ch), s, e.stk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid == 3'b111) all3 = 1'b1;
            if (valid[0]) check_ch(0, int'(duty_r), int'(period_r), int'(stuck[0]));
            if (valid[1]) check_ch(1, int'(duty_g), int'(period_g), int'(stuck[1]));
            if (valid[2]) check_ch(2, int'(duty_b), int'(period_b), int'(stuck[2]));
        end
    end

    task automatic drive(input logic r, input logic g, input logic b);
        @(posedge clk);
        #1;
        RGB_R = r;
        RGB_G = g;
        RGB_B = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_duty_r"}, int'(duty_r), 0);
        chk({tag, "_duty_g"}, int'(duty_g), 0);
        chk({tag, "_duty_b"}, int'(duty_b), 0);
        chk({tag, "_period_r"}, int'(period_r), 0);
        chk({tag, "_period_g"}, int'(period_g), 0);
        chk({tag, "_period_b"}, int'(period_b), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_q_r_empty"}, q_r.size(), 0);
        chk({tag, "_q_g_empty"}, q_g.size(), 0);
        chk({tag, "_q_b_empty"}, q_b.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        RGB_R = 1'b0;
        RGB_G = 1'b0;
        RGB_B = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        all3 = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        RGB_R = 1'b0;
        RGB_G = 1'b0;
        RGB_B = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // 25% duty on R: three measurements from the second edge on
        for (int k = 0; k < 3; k++) push(0, 300, 1200, 0);
        for (int t = 0; t < 3610; t++) drive((t % 1200) < 300, 1'b0, 1'b0);
        idle(5);
        chk("t1_stuck", int'(stuck), 0);
        check_empty("t1");
        do_reset();

        // 0% / 50% / 99%: R pulses once then times out alongside G/B edges
        push(1, 600, 1200, 0);
        push(1, 600, 1200, 0);
        push(2, 1188, 1200, 0);
        push(2, 1188, 1200, 0);
        push(0, 0, 1200, 1);
        for (int t = 0; t < 2410; t++)
            drive(t == 0, (t % 1200) < 600, (t % 1200) < 1188);
        idle(5);
        chk("t2_valid_all3", int'(all3), 1);
        chk("t2_stuck", int'(stuck), 1);
        check_empty("t2");
        do_reset();

        // G high for 3000 cycles: stuck high, then a new edge clears it silently
        push(1, 1200, 1200, 1);
        for (int t = 0; t < 3200; t++) begin
            drive(1'b0, (t < 3000) || (t >= 3100), 1'b0);
            if (t == 2600) chk("t3_stuck_set", int'(stuck), 2);
            if (t == 3150) chk("t3_stuck_clr", int'(stuck), 0);
        end
        idle(5);
        check_empty("t3");
        do_reset();

        // B: 1-cycle pulse every 10 cycles
        for (int k = 0; k < 5; k++) push(2, 1, 10, 0);
        for (int t = 0; t < 55; t++) drive(1'b0, 1'b0, (t % 10) == 0);
        idle(5);
        check_empty("t4");
        do_reset();

        // reset mid-period on a running 25% signal
        push(0, 300, 1200, 0);
        for (int t = 0; t < 3620; t++) begin
            if (t == 1800) begin
                @(posedge clk);
                #1;
                rst   = 1'b1;
                RGB_R = 1'b0;
            end else if (t == 1801) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_zero("t5_midreset");
                chk("t5_q_r_consumed", q_r.size(), 0);
                push(0, 300, 1200, 0);
            end else begin
                drive((t % 1200) < 300, 1'b0, 1'b0);
            end
        end
        idle(5);
        check_empty("t5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, the nominal PWM period in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the duty and period counters and outputs; it SHALL satisfy CNT_W >= clog2(2*PWM_INTERVAL+1), with an elaboration-time error otherwise.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports RGB_R, RGB_G, RGB_B, input, 1 bit each: asynchronous PWM inputs (channels 0, 1, 2).
REQ-006 SHALL have ports duty_r, duty_g, duty_b, output, CNT_W each: last measured high-time in cycles.
REQ-007 SHALL have ports period_r, period_g, period_b, output, CNT_W each: last measured period in cycles.
REQ-008 SHALL have port valid, output, 3 bits: bit i pulses for one cycle when channel i's duty/period outputs update.
REQ-009 SHALL have port stuck, output, 3 bits: bit i is a level, high while channel i has had no rising edge for 2*PWM_INTERVAL cycles.

Function (per channel, channels fully independent)
REQ-010 SHALL pass each input through a 2-flop synchronizer; a rising edge SHALL be detected when the synced bit is 1 and its previous value is 0.
REQ-011 SHALL register all outputs; valid SHALL assert 3 clk edges after the first clk edge that samples the raw input high.
REQ-012 SHALL implement states IDLE, MEASURE and STUCK; reset SHALL enter IDLE.
REQ-013 IDLE: counters held at 0; a rising edge SHALL move to MEASURE with period_cnt=1 and high_cnt=1, and SHALL NOT pulse valid.
REQ-014 MEASURE, no edge: period_cnt SHALL increment every cycle; high_cnt SHALL increment when the synced level is 1.
REQ-015 MEASURE, rising edge: SHALL latch period=period_cnt and duty=high_cnt (pre-increment values), pulse valid[i], and restart both counters at 1.
REQ-016 Edge and timeout in the same cycle: the rising edge SHALL take priority.
REQ-017 MEASURE, period_cnt reaching 2*PWM_INTERVAL with no edge: SHALL go to STUCK, set stuck[i]=1, pulse valid[i] once, and load period=PWM_INTERVAL and duty=(synced level ? PWM_INTERVAL : 0).
REQ-018 STUCK: counters SHALL be frozen (no wrap-around) and outputs held; a rising edge SHALL clear stuck[i], enter MEASURE with counters at 1/1, and SHALL NOT pulse valid.
REQ-019 Counters SHALL never exceed 2*PWM_INTERVAL and SHALL never wrap.
REQ-020 Simultaneous events on different channels SHALL be handled independently in the same cycle (for example, valid=3'b111).
REQ-021 duty SHALL always be <= period on every output update.

Reset
REQ-022 With rst high at a clk edge, all duty/period outputs, valid, stuck, counters and synchronizer flops SHALL become 0 and all channels SHALL enter IDLE.
REQ-023 Reset mid-measurement SHALL discard partial counts; the first valid after reset SHALL require two rising edges.
REQ-024 rst SHALL take priority over all other events in the same cycle.

Verification
REQ-025 RGB_R at 300 high / 900 low, repeating -> from the second rising edge on, duty_r=300, period_r=1200, valid[0] one cycle per period, stuck[0]=0.
REQ-026 R/G/B at 0%, 50% and 99% of 1200, rising edges aligned -> valid=3'b111 in one cycle, duties 0/600/1188; the 0% channel becomes stuck with duty 0.
REQ-027 RGB_G rises once and then stays high for 3000 cycles -> 2400 cycles after that edge, stuck[1]=1, duty_g=1200, period_g=1200, exactly one valid[1] pulse; the next rising edge clears stuck[1] with no valid pulse.
REQ-028 RGB_B as a 1-cycle high pulse every 10 cycles -> duty_b=1, period_b=10 on each valid[2].
REQ-029 rst asserted for 1 cycle mid-period on a running 25% signal -> all outputs 0 next cycle; the next valid carries correct values only after two further rising edges.
